// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle ALU controller: control codes, op classes,
// R-type funct codes, decode result and FSM state.
package alu_mc_pkg;

  localparam logic [2:0] CTL_AND   = 3'b000;
  localparam logic [2:0] CTL_OR    = 3'b001;
  localparam logic [2:0] CTL_ADD   = 3'b010;
  localparam logic [2:0] CTL_MULTU = 3'b011;
  localparam logic [2:0] CTL_SUB   = 3'b110;
  localparam logic [2:0] CTL_SLT   = 3'b111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  typedef struct packed {
    logic [2:0] ctl;
    logic       illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Unsigned shift-add multiplier: one iteration per step, WIDTH steps per product.
module alu_mc_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done_iter,
  output logic [2*WIDTH-1:0] product_next
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     sum;

  // Low half starts as the multiplier and is shifted out as the product grows in.
  assign sum          = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign product_next = {sum, prod[WIDTH-1:1]};
  assign done_iter    = step && (count == LAST);

  always_ff @(posedge clk) begin
    if (load) begin
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
    end else if (step) begin
      prod  <= product_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (load) count <= '0;
    else if (step) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/alu_mc_ctrl.sv
// Multi-cycle ALU controller: decodes op class/funct, runs single-cycle ops at once
// and multu through the shift-add multiplier, then pulses done for one cycle.
module alu_mc_ctrl
  import alu_mc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] funct,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [2:0]        alu_ctl,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic              zero,
  output logic              illegal
);

  state_t               state, state_nxt;
  dec_t                 dec;
  logic                 is_mul, accept, step, load, done_iter;
  logic [2*WIDTH-1:0]   product_next;

  function automatic dec_t decode(input logic [1:0] op, input logic [FUNC_W-1:0] fn);
    dec_t d;
    d.ctl     = CTL_AND;
    d.illegal = 1'b0;
    case (op)
      OP_ADD: d.ctl = CTL_ADD;
      OP_SUB: d.ctl = CTL_SUB;
      OP_OR:  d.ctl = CTL_OR;
      default: begin
        if      (fn == FUNC_W'(FN_ADD))   d.ctl = CTL_ADD;
        else if (fn == FUNC_W'(FN_SUB))   d.ctl = CTL_SUB;
        else if (fn == FUNC_W'(FN_AND))   d.ctl = CTL_AND;
        else if (fn == FUNC_W'(FN_OR))    d.ctl = CTL_OR;
        else if (fn == FUNC_W'(FN_SLT))   d.ctl = CTL_SLT;
        else if (fn == FUNC_W'(FN_MULTU)) d.ctl = CTL_MULTU;
        else                              d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] calc(input logic [2:0] ctl,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (ctl)
      CTL_AND: r = x & y;
      CTL_OR:  r = x | y;
      CTL_ADD: r = x + y;
      CTL_SUB: r = x - y;
      CTL_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign dec    = decode(alu_op, funct);
  assign is_mul = !dec.illegal && (dec.ctl == CTL_MULTU);
  assign load   = accept && is_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = is_mul ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        step = 1'b1;
        if (done_iter) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .step         (step),
    .a            (a),
    .b            (b),
    .done_iter    (done_iter),
    .product_next (product_next)
  );

  // Result words only change at acceptance or on the final multiply step,
  // so partial products never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctl   <= CTL_AND;
      illegal   <= 1'b0;
      result    <= '0;
      result_hi <= '0;
    end else if (accept) begin
      alu_ctl <= dec.ctl;
      illegal <= dec.illegal;
      if (!is_mul) begin
        result    <= dec.illegal ? '0 : calc(dec.ctl, a, b);
        result_hi <= '0;
      end
    end else if (done_iter) begin
      {result_hi, result} <= product_next;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign zero = ~|{result_hi, result};

endmodule

// File: tb/tb_alu_mc_ctrl.sv
// Randomized and directed bench for alu_mc_ctrl against a behavioural op model.
module tb_alu_mc_ctrl;

  localparam int W  = 32;
  localparam int FW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic [1:0]    alu_op;
  logic [FW-1:0] funct;
  logic [W-1:0]  a, b;
  logic          busy, done, zero, illegal;
  logic [2:0]    alu_ctl;
  logic [W-1:0]  result, result_hi;

  logic          start8;
  logic [1:0]    alu_op8;
  logic [FW-1:0] funct8;
  logic [7:0]    a8, b8;
  logic          busy8, done8, zero8, illegal8;
  logic [2:0]    alu_ctl8;
  logic [7:0]    result8, result_hi8;

  int n_chk  = 0;
  int n_pass = 0;

  logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011001};

  always #5 clk = ~clk;

  alu_mc_ctrl #(.WIDTH(W), .FUNC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .alu_ctl(alu_ctl),
    .result(result), .result_hi(result_hi), .zero(zero), .illegal(illegal)
  );

  alu_mc_ctrl #(.WIDTH(8), .FUNC_W(FW)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_op(alu_op8), .funct(funct8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .alu_ctl(alu_ctl8),
    .result(result8), .result_hi(result_hi8), .zero(zero8), .illegal(illegal8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference: decode table and plain arithmetic on the full 2*W product.
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [2:0] ctl, output logic ill,
                                output logic [63:0] full);
    logic [31:0] lo;
    ill  = 1'b0;
    ctl  = 3'b000;
    full = 64'd0;
    lo   = 32'd0;
    case (op)
      2'b00: ctl = 3'b010;
      2'b01: ctl = 3'b110;
      2'b11: ctl = 3'b001;
      default: begin
        case (fn)
          6'b100000: ctl = 3'b010;
          6'b100010: ctl = 3'b110;
          6'b100100: ctl = 3'b000;
          6'b100101: ctl = 3'b001;
          6'b101010: ctl = 3'b111;
          6'b011001: ctl = 3'b011;
          default:   ill = 1'b1;
        endcase
      end
    endcase
    if (!ill) begin
      case (ctl)
        3'b010: lo = x + y;
        3'b110: lo = x - y;
        3'b000: lo = x & y;
        3'b001: lo = x | y;
        3'b111: lo = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
        default: lo = 32'd0;
      endcase
      if (ctl == 3'b011) full = 64'(x) * 64'(y);
      else               full = {32'd0, lo};
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_alu_ctl"}, alu_ctl, 0);
    check({tag, "_result"},  result, 0);
    check({tag, "_hi"},      result_hi, 0);
    check({tag, "_zero"},    zero, 1);
    check({tag, "_illegal"}, illegal, 0);
  endtask

  // poke holds start high (with junk operands) through MUL and DONE; it must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] x, input logic [31:0] y, input bit poke);
    logic [2:0]  ectl;
    logic        eill;
    logic [63:0] efull;
    int          lat, elat;
    model(op, fn, x, y, ectl, eill, efull);
    elat = (!eill && ectl == 3'b011) ? W : 0;
    @(negedge clk);
    start = 1'b1; alu_op = op; funct = fn; a = x; b = y;
    @(posedge clk); #1;
    start  = poke;
    a      = $urandom;
    b      = $urandom;
    alu_op = 2'($urandom);
    funct  = 6'($urandom);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency",   lat, elat);
    check("busy_done", busy, 1);
    check("result",    result, efull[31:0]);
    check("result_hi", result_hi, efull[63:32]);
    check("zero",      zero, efull == 64'd0);
    check("illegal",   illegal, eill);
    if (!eill) check("alu_ctl", alu_ctl, ectl);
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse",  done, 0);
    check("idle_busy",   busy, 0);
    check("hold_result", {result_hi, result}, efull);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat8;
    logic [1:0]  rop;
    logic [5:0]  rfn;
    int          sel;
    start = 0; alu_op = 0; funct = 0; a = 0; b = 0;
    start8 = 0; alu_op8 = 2'b10; funct8 = 6'b011001; a8 = 0; b8 = 0;
    #1;
    check_reset_vals("rst");
    check("rst_zero8", zero8, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op(2'b10, 6'b100000, 32'd5, 32'd7, 0);
    run_op(2'b01, 6'd0, 32'h1234, 32'h1234, 0);
    run_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 0);
    run_op(2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2'b10, 6'b011001, $urandom, $urandom, 1);
    run_op(2'b00, 6'd0, $urandom, $urandom, 1);
    run_op(2'b10, 6'b111111, $urandom, $urandom, 0);
    run_op(2'b11, 6'd0, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run_op(2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    run_op(2'b10, 6'b100010, 32'd0, 32'd1, 0);
    run_op(2'b00, 6'd0, 32'hFFFFFFFF, 32'd1, 0);
    run_op(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      rfn = (sel < 6) ? fns[sel] : 6'($urandom);
      run_op(rop, rfn, $urandom, $urandom, bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; alu_op = 2'b10; funct = 6'b011001; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midmul");
    repeat (3) @(posedge clk);
    #1;
    check("midmul_no_done", done, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(2'b00, 6'd0, 32'd3, 32'd4, 0);

    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat8 = 0;
    while (!done8 && lat8 < 100) begin
      @(posedge clk); #1;
      lat8++;
    end
    check("w8_latency", lat8, 8);
    check("w8_product", {result_hi8, result8}, 16'hFE01);
    check("w8_zero",    zero8, 0);
    check("w8_alu_ctl", alu_ctl8, 3'b011);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
